overlay_scheduler: RTL and testbench
====================================

// Module: overlay_scheduler
// PURPOSE
//  Sequences the two text overlays of the graphics engine: a bouncing 23x9-cell logo (layer 0) and a
//  blinking 47x9-cell banner (layer 1). Cell = 8x8 px on a 640x480 raster (80x60 cells).
//  Once per frame, during vertical blanking, it updates the layer origins and blink state.
//  Per pixel, it arbitrates the shared RGB output between the two layers' glyph-hit signals.
// PARAMETERS
//  H_CELLS    80   screen width in cells
//  V_CELLS    60   screen height in cells
//  L0_W/L0_H  23/9 layer 0 size in cells
//  L0_X0/L0_Y0 30/24 layer 0 origin after reset
//  L1_X0/L1_Y0 18/12 layer 1 origin (fixed)
//  FRAME_DIV  2    layer 0 moves once every FRAME_DIV frames (1..15)
//  BLINK_ON   45   frames layer 1 is visible per blink period (1..255)
//  BLINK_OFF  15   frames layer 1 is hidden per blink period (0..255; 0 = always on)
// PORTS
//  clk         in   1   pixel clock
//  rst         in   1   synchronous, active-high reset
//  x, y        in   10  current raster pixel coordinates
//  frame_active in  1   1 while (x,y) is inside the visible 640x480 area
//  anim_en     in   1   1 = animate; 0 = freeze positions and blink state
//  l0_hit      in   1   layer 0 glyph bit at (x,y), relative to l0_org_*
//  l1_hit      in   1   layer 1 glyph bit at (x,y), relative to l1_org_*
//  l0_org_x    out  7   layer 0 origin column (cells)
//  l0_org_y    out  6   layer 0 origin row (cells)
//  l1_org_x    out  7   layer 1 origin column = L1_X0
//  l1_org_y    out  6   layer 1 origin row = L1_Y0
//  l1_vis      out  1   layer 1 currently visible
//  frame_tick  out  1   one-cycle pulse at the start of vblank
//  pix_sel     out  2   00 none, 01 layer 0, 10 layer 1 (registered)
//  rgb         out  6   {r[1:0],g[1:0],b[1:0]}; 6'h3F when pix_sel!=0, else 6'h00
// BEHAVIOUR
//  Reset: l0_org=(L0_X0,L0_Y0), dir_x=+1, dir_y=+1, l1_vis=1, frame/blink counters=0,
//   frame_tick=0, pix_sel=00, rgb=0, FSM=S_WAIT. Reset applies on the next edge and also
//   mid-update; it overrides all other events.
//  frame_tick: asserted for one cycle when x==0 && y==480.
//  FSM: S_WAIT -> S_MOVE on frame_tick && anim_en; S_MOVE -> S_BLINK -> S_WAIT, one cycle each.
//   Origins change only in S_MOVE/S_BLINK, i.e., never inside the visible area.
//   frame_tick with anim_en=0: stay in S_WAIT; no counters advance.
//  S_MOVE: frame_div counter increments and wraps at FRAME_DIV-1. On the wrap cycle, layer 0 steps:
//   x: if dir_x=+1 and org_x==H_CELLS-L0_W (57) -> dir_x=-1, org_x-=1;
//      if dir_x=-1 and org_x==0 -> dir_x=+1, org_x+=1; otherwise org_x+=dir_x.
//   y: same rule with bound V_CELLS-L0_H (51). Both axes may flip in the same step (corner).
//   Origins never leave [0,57]x[0,51]; arithmetic is unsigned, with no wrap-around.
//  S_BLINK: blink counter increments. When l1_vis=1 and count==BLINK_ON-1 -> l1_vis=0, count=0
//   (skipped if BLINK_OFF==0). When l1_vis=0 and count==BLINK_OFF-1 -> l1_vis=1, count=0.
//  Arbiter (every cycle, 1-cycle latency): if !frame_active -> 00;
//   else if l1_hit && l1_vis -> 10; else if l0_hit -> 01; else 00. Layer 1 wins ties.
//  rgb follows pix_sel in the same registered cycle. Hit inputs are sampled the same edge as x,y.
// TESTING
//  1 Reset: hold rst 3 cycles mid-frame -> l0_org=(30,24), l1_vis=1, pix_sel=00, rgb=0 next cycle.
//  2 Steps: anim_en=1, run 4 frames -> after frames 2 and 4, l0_org=(31,25) then (32,26);
//    no change while frame_active=1.
//  3 Bounce: preload by running until org_x=57 with dir_x=+1 -> next step gives org_x=56, dir_x=-1;
//    at the (0,0) corner both dirs flip and the origin becomes (1,1).
//  4 Blink: 60 frames -> l1_vis=0 after frame 45 for 15 frames, then back to 1 after frame 60.
//  5 Arbitration: frame_active=1, l0_hit=l1_hit=1, l1_vis=1 -> pix_sel=10, rgb=3F one cycle later;
//    l1_vis=0 -> 01; frame_active=0 -> 00.
//  6 Freeze/reset mid-update: anim_en=0 for 10 frames -> origins and l1_vis constant;
//    rst asserted in S_MOVE -> reset values, with no partial step.

Source files
------------

// File: rtl/overlay_scheduler.sv
// overlay_scheduler: per-frame origin/blink sequencing for the logo (layer 0)
// and banner (layer 1) overlays, plus the per-pixel arbiter that drives the
// shared RGB output.
module overlay_scheduler #(
    parameter int H_CELLS   = 80,
    parameter int V_CELLS   = 60,
    parameter int L0_W      = 23,
    parameter int L0_H      = 9,
    parameter int L0_X0     = 30,
    parameter int L0_Y0     = 24,
    parameter int L1_X0     = 18,
    parameter int L1_Y0     = 12,
    parameter int FRAME_DIV = 2,
    parameter int BLINK_ON  = 45,
    parameter int BLINK_OFF = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       frame_active,
    input  logic       anim_en,
    input  logic       l0_hit,
    input  logic       l1_hit,
    output logic [6:0] l0_org_x,
    output logic [5:0] l0_org_y,
    output logic [6:0] l1_org_x,
    output logic [5:0] l1_org_y,
    output logic       l1_vis,
    output logic       frame_tick,
    output logic [1:0] pix_sel,
    output logic [5:0] rgb
);

    // Rightmost / bottommost legal origin for layer 0.
    localparam logic [6:0] X_MAX    = 7'(H_CELLS - L0_W);
    localparam logic [5:0] Y_MAX    = 6'(V_CELLS - L0_H);
    localparam logic [9:0] VBLANK_Y = 10'(V_CELLS * 8);
    localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);
    localparam logic [7:0] ON_LAST  = 8'(BLINK_ON - 1);
    // Wraps to all-ones when BLINK_OFF is 0; the hidden phase is never entered then.
    localparam logic [7:0] OFF_LAST = 8'(BLINK_OFF - 1);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_MOVE  = 2'd1,
        S_BLINK = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       dir_x_pos, dir_y_pos;
    logic [3:0] div_cnt;
    logic [7:0] blink_cnt;

    logic       step;
    logic [3:0] div_nxt;
    logic [6:0] org_x_nxt;
    logic [5:0] org_y_nxt;
    logic       dir_x_nxt, dir_y_nxt;
    logic [7:0] blink_nxt;
    logic       vis_nxt;
    logic [1:0] sel_nxt;

    assign l1_org_x = 7'(L1_X0);
    assign l1_org_y = 6'(L1_Y0);

    // Pulse once per frame on the first blanking pixel below the visible area.
    always_ff @(posedge clk) begin
        if (rst) frame_tick <= 1'b0;
        else     frame_tick <= (x == 10'd0) && (y == VBLANK_Y);
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_WAIT;
        else     state <= state_nxt;
    end

    // Sequencer next state: one move cycle then one blink cycle per animated frame.
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:  if (frame_tick && anim_en) state_nxt = S_MOVE;
            S_MOVE:  state_nxt = S_BLINK;
            S_BLINK: state_nxt = S_WAIT;
            default: state_nxt = S_WAIT;
        endcase
    end

    // Candidate layer-0 step and frame divider; a bound reverses the direction
    // and steps back inward in the same frame, so the origin never leaves range.
    always_comb begin
        step    = (div_cnt == DIV_LAST);
        div_nxt = step ? 4'd0 : div_cnt + 4'd1;

        if (dir_x_pos) begin
            if (l0_org_x == X_MAX) begin dir_x_nxt = 1'b0; org_x_nxt = l0_org_x - 7'd1; end
            else                   begin dir_x_nxt = 1'b1; org_x_nxt = l0_org_x + 7'd1; end
        end else begin
            if (l0_org_x == 7'd0)  begin dir_x_nxt = 1'b1; org_x_nxt = l0_org_x + 7'd1; end
            else                   begin dir_x_nxt = 1'b0; org_x_nxt = l0_org_x - 7'd1; end
        end

        if (dir_y_pos) begin
            if (l0_org_y == Y_MAX) begin dir_y_nxt = 1'b0; org_y_nxt = l0_org_y - 6'd1; end
            else                   begin dir_y_nxt = 1'b1; org_y_nxt = l0_org_y + 6'd1; end
        end else begin
            if (l0_org_y == 6'd0)  begin dir_y_nxt = 1'b1; org_y_nxt = l0_org_y + 6'd1; end
            else                   begin dir_y_nxt = 1'b0; org_y_nxt = l0_org_y - 6'd1; end
        end
    end

    // Blink phase counter: ON frames visible, OFF frames hidden (OFF = 0 keeps it on).
    always_comb begin
        vis_nxt   = l1_vis;
        blink_nxt = blink_cnt + 8'd1;
        if (l1_vis && (blink_cnt == ON_LAST)) begin
            blink_nxt = 8'd0;
            if (BLINK_OFF != 0) vis_nxt = 1'b0;
        end else if (!l1_vis && (blink_cnt == OFF_LAST)) begin
            blink_nxt = 8'd0;
            vis_nxt   = 1'b1;
        end
    end

    // Layer state updates, confined to the blanking-interval move/blink cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            l0_org_x  <= 7'(L0_X0);
            l0_org_y  <= 6'(L0_Y0);
            dir_x_pos <= 1'b1;
            dir_y_pos <= 1'b1;
            div_cnt   <= 4'd0;
            blink_cnt <= 8'd0;
            l1_vis    <= 1'b1;
        end else begin
            case (state)
                S_MOVE: begin
                    div_cnt <= div_nxt;
                    if (step) begin
                        l0_org_x  <= org_x_nxt;
                        l0_org_y  <= org_y_nxt;
                        dir_x_pos <= dir_x_nxt;
                        dir_y_pos <= dir_y_nxt;
                    end
                end
                S_BLINK: begin
                    blink_cnt <= blink_nxt;
                    l1_vis    <= vis_nxt;
                end
                default: ;
            endcase
        end
    end

    // Pixel priority: banner over logo, nothing outside the visible area.
    always_comb begin
        sel_nxt = 2'b00;
        if (frame_active) begin
            if (l1_hit && l1_vis) sel_nxt = 2'b10;
            else if (l0_hit)      sel_nxt = 2'b01;
        end
    end

    // Registered pixel select and colour, updated together.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_sel <= 2'b00;
            rgb     <= 6'h00;
        end else begin
            pix_sel <= sel_nxt;
            rgb     <= (sel_nxt != 2'b00) ? 6'h3F : 6'h00;
        end
    end

endmodule

// File: tb/tb_overlay_scheduler.sv
// Testbench for overlay_scheduler: compressed raster frames with random pixel
// traffic, checked against a closed-form model of the bounce and blink rules.
module tb_overlay_scheduler;

    localparam int XMAX = 80 - 23;
    localparam int YMAX = 60 - 9;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x, y;
    logic       frame_active, anim_en, l0_hit, l1_hit;
    logic [6:0] l0_org_x, l1_org_x;
    logic [5:0] l0_org_y, l1_org_y;
    logic       l1_vis, frame_tick;
    logic [1:0] pix_sel;
    logic [5:0] rgb;

    int tests = 0;
    int fails = 0;
    int n_anim = 0;   // animated frames since the last reset

    always #5 clk = ~clk;

    overlay_scheduler dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .frame_active(frame_active),
        .anim_en(anim_en), .l0_hit(l0_hit), .l1_hit(l1_hit),
        .l0_org_x(l0_org_x), .l0_org_y(l0_org_y), .l1_org_x(l1_org_x), .l1_org_y(l1_org_y),
        .l1_vis(l1_vis), .frame_tick(frame_tick), .pix_sel(pix_sel), .rgb(rgb)
    );

    // Bouncing coordinate as a triangle wave: unfold the reflections into a
    // straight run of period 2*max starting at 'start' heading upward.
    function automatic int tri_pos(input int start, input int mx, input int s);
        int u;
        u = (start + s) % (2 * mx);
        return (u <= mx) ? u : 2 * mx - u;
    endfunction

    function automatic int exp_x();
        return tri_pos(30, XMAX, n_anim / 2);
    endfunction

    function automatic int exp_y();
        return tri_pos(24, YMAX, n_anim / 2);
    endfunction

    function automatic logic exp_vis();
        return (n_anim % 60) < 45;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_active = 1'b0; x = 10'd5; y = 10'd5;
        cyc(); cyc();
        rst = 1'b0;
        n_anim = 0;
    endtask

    // One compressed frame: vblank start, 4 blanking pixels, nvis random visible pixels.
    task automatic run_frame(input int nvis);
        logic [1:0] esel;
        x = 10'd0; y = 10'd480; frame_active = 1'b0;
        l0_hit = 1'($urandom_range(0, 1)); l1_hit = 1'($urandom_range(0, 1));
        cyc();
        tests++; if (frame_tick !== 1'b1) begin fails++; $display("FAIL frame_tick_pulse: got %b want 1", frame_tick); end
        tests++; if (pix_sel !== 2'b00) begin fails++; $display("FAIL blank_pix_sel: got %b want 00", pix_sel); end
        for (int i = 0; i < 4; i++) begin
            x = 10'(i + 1);
            cyc();
            if (i == 0) begin
                tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL frame_tick_width: got %b want 0", frame_tick); end
            end
        end
        if (anim_en) n_anim++;
        tests++; if (l0_org_x !== 7'(exp_x())) begin fails++; $display("FAIL frame_org_x: frame %0d got %0d want %0d", n_anim, l0_org_x, exp_x()); end
        tests++; if (l0_org_y !== 6'(exp_y())) begin fails++; $display("FAIL frame_org_y: frame %0d got %0d want %0d", n_anim, l0_org_y, exp_y()); end
        tests++; if (l1_vis !== exp_vis()) begin fails++; $display("FAIL frame_l1_vis: frame %0d got %b want %b", n_anim, l1_vis, exp_vis()); end
        for (int i = 0; i < nvis; i++) begin
            x = 10'($urandom_range(0, 639)); y = 10'($urandom_range(0, 479));
            frame_active = 1'b1;
            l0_hit = 1'($urandom_range(0, 1)); l1_hit = 1'($urandom_range(0, 1));
            esel = (l1_hit && exp_vis()) ? 2'b10 : (l0_hit ? 2'b01 : 2'b00);
            cyc();
            tests++; if (pix_sel !== esel) begin fails++; $display("FAIL vis_pix_sel: got %b want %b", pix_sel, esel); end
            tests++; if (rgb !== ((esel != 2'b00) ? 6'h3F : 6'h00)) begin fails++; $display("FAIL vis_rgb: got %h sel %b", rgb, esel); end
            tests++; if (l0_org_x !== 7'(exp_x()) || l0_org_y !== 6'(exp_y())) begin
                fails++; $display("FAIL vis_org_stable: got (%0d,%0d) want (%0d,%0d)", l0_org_x, l0_org_y, exp_x(), exp_y());
            end
        end
        frame_active = 1'b0;
    endtask

    task automatic test_reset();
        x = 10'd100; y = 10'd100; frame_active = 1'b1; l0_hit = 1'b1; l1_hit = 1'b1; anim_en = 1'b1;
        rst = 1'b1;
        cyc(); cyc(); cyc();
        tests++; if (l0_org_x !== 7'd30 || l0_org_y !== 6'd24) begin fails++; $display("FAIL reset_org: got (%0d,%0d) want (30,24)", l0_org_x, l0_org_y); end
        tests++; if (l1_vis !== 1'b1) begin fails++; $display("FAIL reset_l1_vis: got %b want 1", l1_vis); end
        tests++; if (pix_sel !== 2'b00 || rgb !== 6'h00) begin fails++; $display("FAIL reset_pix: got sel %b rgb %h want 00/00", pix_sel, rgb); end
        tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
        tests++; if (l1_org_x !== 7'd18 || l1_org_y !== 6'd12) begin fails++; $display("FAIL l1_org: got (%0d,%0d) want (18,12)", l1_org_x, l1_org_y); end
        rst = 1'b0; frame_active = 1'b0;
        n_anim = 0;
    endtask

    task automatic test_steps();
        do_reset();
        anim_en = 1'b1;
        for (int f = 1; f <= 4; f++) begin
            run_frame(6);
            if (f == 2) begin
                tests++; if (l0_org_x !== 7'd31 || l0_org_y !== 6'd25) begin fails++; $display("FAIL step_f2: got (%0d,%0d) want (31,25)", l0_org_x, l0_org_y); end
            end
            if (f == 4) begin
                tests++; if (l0_org_x !== 7'd32 || l0_org_y !== 6'd26) begin fails++; $display("FAIL step_f4: got (%0d,%0d) want (32,26)", l0_org_x, l0_org_y); end
            end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        anim_en = 1'b1;
        while (n_anim < 1996) begin
            run_frame(2);
            if (n_anim == 54) begin
                tests++; if (l0_org_x !== 7'd57 || l0_org_y !== 6'd51) begin fails++; $display("FAIL bounce_far: got (%0d,%0d) want (57,51)", l0_org_x, l0_org_y); end
            end
            if (n_anim == 56) begin
                tests++; if (l0_org_x !== 7'd56 || l0_org_y !== 6'd50) begin fails++; $display("FAIL bounce_back: got (%0d,%0d) want (56,50)", l0_org_x, l0_org_y); end
            end
            if (n_anim == 1992) begin
                tests++; if (l0_org_x !== 7'd0 || l0_org_y !== 6'd0) begin fails++; $display("FAIL corner_hit: got (%0d,%0d) want (0,0)", l0_org_x, l0_org_y); end
            end
            if (n_anim == 1994) begin
                tests++; if (l0_org_x !== 7'd1 || l0_org_y !== 6'd1) begin fails++; $display("FAIL corner_flip: got (%0d,%0d) want (1,1)", l0_org_x, l0_org_y); end
            end
        end
    endtask

    task automatic test_blink();
        do_reset();
        anim_en = 1'b1;
        for (int f = 1; f <= 60; f++) begin
            run_frame(3);
            if (f == 44 || f == 45 || f == 59 || f == 60) begin
                tests++;
                if (l1_vis !== ((f == 44 || f == 60) ? 1'b1 : 1'b0)) begin
                    fails++; $display("FAIL blink_f%0d: got %b", f, l1_vis);
                end
            end
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        anim_en = 1'b1;
        x = 10'd200; y = 10'd200; frame_active = 1'b1; l0_hit = 1'b1; l1_hit = 1'b1;
        cyc();
        tests++; if (pix_sel !== 2'b10 || rgb !== 6'h3F) begin fails++; $display("FAIL arb_tie_vis: got sel %b rgb %h want 10/3f", pix_sel, rgb); end
        for (int f = 0; f < 45; f++) run_frame(1);
        x = 10'd201; y = 10'd200; frame_active = 1'b1; l0_hit = 1'b1; l1_hit = 1'b1;
        cyc();
        tests++; if (pix_sel !== 2'b01 || rgb !== 6'h3F) begin fails++; $display("FAIL arb_tie_hidden: got sel %b rgb %h want 01/3f", pix_sel, rgb); end
        l0_hit = 1'b0;
        cyc();
        tests++; if (pix_sel !== 2'b00 || rgb !== 6'h00) begin fails++; $display("FAIL arb_l1_hidden: got sel %b rgb %h want 00/00", pix_sel, rgb); end
        frame_active = 1'b0; l0_hit = 1'b1;
        cyc();
        tests++; if (pix_sel !== 2'b00 || rgb !== 6'h00) begin fails++; $display("FAIL arb_inactive: got sel %b rgb %h want 00/00", pix_sel, rgb); end
    endtask

    task automatic test_freeze_and_reset();
        do_reset();
        anim_en = 1'b1;
        for (int f = 0; f < 5; f++) run_frame(2);
        anim_en = 1'b0;
        for (int f = 0; f < 10; f++) run_frame(2);
        tests++; if (l0_org_x !== 7'd32 || l0_org_y !== 6'd26) begin fails++; $display("FAIL freeze_org: got (%0d,%0d) want (32,26)", l0_org_x, l0_org_y); end
        anim_en = 1'b1;
        // This frame would step (odd divider phase); reset lands in the move cycle.
        x = 10'd0; y = 10'd480; frame_active = 1'b0;
        cyc();
        x = 10'd1;
        cyc();
        rst = 1'b1; x = 10'd2;
        cyc();
        tests++; if (l0_org_x !== 7'd30 || l0_org_y !== 6'd24) begin fails++; $display("FAIL midmove_reset_org: got (%0d,%0d) want (30,24)", l0_org_x, l0_org_y); end
        tests++; if (l1_vis !== 1'b1 || pix_sel !== 2'b00) begin fails++; $display("FAIL midmove_reset_ctl: got vis %b sel %b want 1/00", l1_vis, pix_sel); end
        rst = 1'b0; n_anim = 0;
        x = 10'd3; cyc(); x = 10'd4; cyc(); cyc();
        tests++; if (l0_org_x !== 7'd30 || l0_org_y !== 6'd24) begin fails++; $display("FAIL midmove_no_partial: got (%0d,%0d) want (30,24)", l0_org_x, l0_org_y); end
        run_frame(2);
        run_frame(2);
        tests++; if (l0_org_x !== 7'd31 || l0_org_y !== 6'd25) begin fails++; $display("FAIL post_reset_step: got (%0d,%0d) want (31,25)", l0_org_x, l0_org_y); end
    endtask

    initial begin
        rst = 1'b0; x = 10'd0; y = 10'd0; frame_active = 1'b0;
        anim_en = 1'b0; l0_hit = 1'b0; l1_hit = 1'b0;
        test_reset();
        test_steps();
        test_blink();
        test_arbitration();
        test_freeze_and_reset();
        test_bounce();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
